// File: rtl/axi_llc_lock_req.sv
// Lock requester: holds one descriptor, requests its index/way lock once the lock box reports it free, then forwards it.
// Optional cumulative stall counter enabled by defining AXI_LLC_LOCK_REQ_STALL_CNT_EN.
module axi_llc_lock_req #(
   parameter int unsigned IndexLength      = 8,
   parameter int unsigned SetAssociativity = 8,
   parameter int unsigned PayloadWidth     = 32,
   parameter int unsigned StallCntWidth    = 16
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic [IndexLength-1:0]      desc_index_i,
   input  logic [SetAssociativity-1:0] desc_way_i,
   input  logic [PayloadWidth-1:0]     desc_payload_i,
   input  logic                        desc_valid_i,
   output logic                        desc_ready_o,
   output logic [IndexLength-1:0]      lock_index_o,
   output logic [SetAssociativity-1:0] lock_way_o,
   output logic                        lock_req_o,
   input  logic                        locked_i,
   output logic [IndexLength-1:0]      desc_index_o,
   output logic [SetAssociativity-1:0] desc_way_o,
   output logic [PayloadWidth-1:0]     desc_payload_o,
   output logic                        desc_valid_o,
   input  logic                        desc_ready_i,
   output logic [StallCntWidth-1:0]    stall_cnt_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      SEND = 2'd2
   } state_e;

   state_e                        state_q, state_d;
   logic                          capture;
   logic                          vld_p0;
   logic [IndexLength-1:0]        hold_index_p0;
   logic [SetAssociativity-1:0]   hold_way_p0;
   logic [PayloadWidth-1:0]       hold_payload_p0;

   always_comb begin
      state_d      = state_q;
      capture      = 1'b0;
      desc_ready_o = 1'b0;
      lock_req_o   = 1'b0;
      vld_p0       = 1'b0;
      case (state_q)
         IDLE: begin
            desc_ready_o = 1'b1;
            if (desc_valid_i) begin
               capture = 1'b1;
               state_d = WAIT;
            end
         end
         WAIT: begin
            // The request is issued only in the single cycle the lock is seen free.
            if (!locked_i) begin
               lock_req_o = 1'b1;
               state_d    = SEND;
            end
         end
         SEND: begin
            vld_p0       = 1'b1;
            desc_ready_o = desc_ready_i;
            if (desc_ready_i) begin
               if (desc_valid_i) begin
                  capture = 1'b1;
                  state_d = WAIT;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---- stage p0: holding register, cleared on reset so a discarded descriptor leaves no trace
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hold_index_p0   <= '0;
         hold_way_p0     <= '0;
         hold_payload_p0 <= '0;
      end else if (capture) begin
         hold_index_p0   <= desc_index_i;
         hold_way_p0     <= desc_way_i;
         hold_payload_p0 <= desc_payload_i;
      end
   end

   assign lock_index_o   = hold_index_p0;
   assign lock_way_o     = hold_way_p0;
   assign desc_index_o   = hold_index_p0;
   assign desc_way_o     = hold_way_p0;
   assign desc_payload_o = hold_payload_p0;
   assign desc_valid_o   = vld_p0;

`ifdef AXI_LLC_LOCK_REQ_STALL_CNT_EN
   localparam logic [StallCntWidth-1:0] CntOne = StallCntWidth'(1);

   logic                     stall;
   logic [StallCntWidth-1:0] stall_cnt_p0;

   function automatic logic [StallCntWidth-1:0] sat_inc(input logic [StallCntWidth-1:0] v);
      return (&v) ? v : v + CntOne;
   endfunction

   assign stall = (state_q == WAIT) && locked_i;

   // Cumulative over all descriptors; only reset clears it.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stall_cnt_p0 <= '0;
      end else if (stall) begin
         stall_cnt_p0 <= sat_inc(stall_cnt_p0);
      end
   end

   assign stall_cnt_o = stall_cnt_p0;
`else
   assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_axi_llc_lock_req.sv
// Self-checking bench for axi_llc_lock_req: directed scenarios plus randomized traffic against a descriptor-level model.
module tb_axi_llc_lock_req;
   localparam int IW  = 8;
   localparam int SA  = 8;
   localparam int PW  = 32;
   localparam int SW  = 16;
   localparam int SW4 = 4;
`ifdef AXI_LLC_LOCK_REQ_STALL_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_ni;
   logic [IW-1:0] desc_index_i;
   logic [SA-1:0] desc_way_i;
   logic [PW-1:0] desc_payload_i;
   logic          desc_valid_i, locked_i, desc_ready_i;

   logic          desc_ready_o, lock_req_o, desc_valid_o;
   logic [IW-1:0] lock_index_o, desc_index_o;
   logic [SA-1:0] lock_way_o, desc_way_o;
   logic [PW-1:0] desc_payload_o;
   logic [SW-1:0] stall_cnt_o;

   logic           desc_ready_o4, lock_req_o4, desc_valid_o4;
   logic [IW-1:0]  lock_index_o4, desc_index_o4;
   logic [SA-1:0]  lock_way_o4, desc_way_o4;
   logic [PW-1:0]  desc_payload_o4;
   logic [SW4-1:0] stall_cnt_o4;

   axi_llc_lock_req #(.IndexLength(IW), .SetAssociativity(SA), .PayloadWidth(PW), .StallCntWidth(SW)) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .desc_index_i(desc_index_i), .desc_way_i(desc_way_i), .desc_payload_i(desc_payload_i),
      .desc_valid_i(desc_valid_i), .desc_ready_o(desc_ready_o),
      .lock_index_o(lock_index_o), .lock_way_o(lock_way_o), .lock_req_o(lock_req_o), .locked_i(locked_i),
      .desc_index_o(desc_index_o), .desc_way_o(desc_way_o), .desc_payload_o(desc_payload_o),
      .desc_valid_o(desc_valid_o), .desc_ready_i(desc_ready_i), .stall_cnt_o(stall_cnt_o)
   );

   axi_llc_lock_req #(.IndexLength(IW), .SetAssociativity(SA), .PayloadWidth(PW), .StallCntWidth(SW4)) dut4 (
      .clk_i(clk), .rst_ni(rst_ni),
      .desc_index_i(desc_index_i), .desc_way_i(desc_way_i), .desc_payload_i(desc_payload_i),
      .desc_valid_i(desc_valid_i), .desc_ready_o(desc_ready_o4),
      .lock_index_o(lock_index_o4), .lock_way_o(lock_way_o4), .lock_req_o(lock_req_o4), .locked_i(locked_i),
      .desc_index_o(desc_index_o4), .desc_way_o(desc_way_o4), .desc_payload_o(desc_payload_o4),
      .desc_valid_o(desc_valid_o4), .desc_ready_i(desc_ready_i), .stall_cnt_o(stall_cnt_o4)
   );

   int checks = 0;
   int errors = 0;

   // Model: is a descriptor held, has its lock already been requested, what is held, how many stall cycles so far.
   bit            m_have, m_granted, n_have, n_granted, pend;
   logic [IW-1:0] m_idx, n_idx;
   logic [SA-1:0] m_way, n_way;
   logic [PW-1:0] m_pay, n_pay;
   longint        m_cnt, n_cnt;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] sat(input longint c, input int w);
      longint mx;
      mx = (longint'(1) << w) - 1;
      return (c > mx) ? 64'(mx) : 64'(c);
   endfunction

   task automatic drive(input bit v, input logic [IW-1:0] idx, input logic [SA-1:0] way,
                        input logic [PW-1:0] pay, input bit lk, input bit rdy, input bit rst = 1'b1);
      bit exp_ready, exp_lreq, exp_valid;
      @(posedge clk);
      if (pend) begin
         m_have = n_have; m_granted = n_granted;
         m_idx = n_idx; m_way = n_way; m_pay = n_pay; m_cnt = n_cnt;
      end
      @(negedge clk);
      rst_ni = rst; desc_valid_i = v; desc_index_i = idx; desc_way_i = way;
      desc_payload_i = pay; locked_i = lk; desc_ready_i = rdy;
      #1;
      if (!rst) begin
         m_have = 0; m_granted = 0; m_idx = '0; m_way = '0; m_pay = '0; m_cnt = 0;
      end
      exp_ready = !m_have || (m_granted && rdy);
      exp_lreq  = rst && m_have && !m_granted && !lk;
      exp_valid = m_have && m_granted;
      chk("desc_ready_o", 64'(desc_ready_o), 64'(exp_ready));
      chk("lock_req_o", 64'(lock_req_o), 64'(exp_lreq));
      chk("desc_valid_o", 64'(desc_valid_o), 64'(exp_valid));
      chk("lock_index_o", 64'(lock_index_o), 64'(m_idx));
      chk("lock_way_o", 64'(lock_way_o), 64'(m_way));
      if (exp_valid) begin
         chk("desc_index_o", 64'(desc_index_o), 64'(m_idx));
         chk("desc_way_o", 64'(desc_way_o), 64'(m_way));
         chk("desc_payload_o", 64'(desc_payload_o), 64'(m_pay));
      end
      chk("stall_cnt_o", 64'(stall_cnt_o), CNT_EN ? sat(m_cnt, SW) : 64'd0);
      chk("stall_cnt_o4", 64'(stall_cnt_o4), CNT_EN ? sat(m_cnt, SW4) : 64'd0);
      chk("lock_req_o4", 64'(lock_req_o4), 64'(exp_lreq));
      chk("desc_ready_o4", 64'(desc_ready_o4), 64'(exp_ready));
      if (exp_valid) chk("desc_payload_o4", 64'(desc_payload_o4), 64'(m_pay));
      n_have = m_have; n_granted = m_granted; n_idx = m_idx; n_way = m_way; n_pay = m_pay; n_cnt = m_cnt;
      if (rst) begin
         if (exp_lreq) n_granted = 1;
         if (m_have && !m_granted && lk) n_cnt = m_cnt + 1;
         if (exp_valid && rdy) n_have = 0;
         if (exp_ready && v) begin
            n_have = 1; n_granted = 0; n_idx = idx; n_way = way; n_pay = pay;
         end
      end
      pend = 1;
   endtask

   initial begin
      rst_ni = 1'b0; desc_valid_i = 1'b0; desc_index_i = '0; desc_way_i = '0;
      desc_payload_i = '0; locked_i = 1'b0; desc_ready_i = 1'b0; pend = 0;
      m_have = 0; m_granted = 0; m_idx = '0; m_way = '0; m_pay = '0; m_cnt = 0;

      drive(1, 8'hFF, 8'hFF, 32'hFFFF_FFFF, 0, 1, 0);
      drive(1, 8'hFF, 8'hFF, 32'hFFFF_FFFF, 0, 1, 0);
      chk("rst_ready", 64'(desc_ready_o), 64'd1);
      chk("rst_valid", 64'(desc_valid_o), 64'd0);
      chk("rst_lreq", 64'(lock_req_o), 64'd0);
      chk("rst_cnt", 64'(stall_cnt_o), 64'd0);
      chk("rst_hold", 64'(lock_index_o), 64'd0);

      // Uncontended
      drive(1, 8'h12, 8'h04, 32'hCAFE, 0, 1);
      chk("unc_N_ready", 64'(desc_ready_o), 64'd1);
      drive(0, 8'h00, 8'h00, 32'h0, 0, 1);
      chk("unc_N1_lreq", 64'(lock_req_o), 64'd1);
      chk("unc_N1_idx", 64'(lock_index_o), 64'h12);
      chk("unc_N1_way", 64'(lock_way_o), 64'h04);
      chk("unc_N1_valid", 64'(desc_valid_o), 64'd0);
      drive(0, 8'h00, 8'h00, 32'h0, 0, 1);
      chk("unc_N2_valid", 64'(desc_valid_o), 64'd1);
      chk("unc_N2_idx", 64'(desc_index_o), 64'h12);
      chk("unc_N2_way", 64'(desc_way_o), 64'h04);
      chk("unc_N2_pay", 64'(desc_payload_o), 64'hCAFE);
      chk("unc_N2_lreq", 64'(lock_req_o), 64'd0);

      // Contention
      drive(1, 8'h34, 8'h01, 32'h1111, 0, 1);
      for (int i = 0; i < 5; i++) begin
         drive(0, 8'h00, 8'h00, 32'h0, 1, 1);
         chk("cont_lreq_blocked", 64'(lock_req_o), 64'd0);
      end
      drive(0, 8'h00, 8'h00, 32'h0, 0, 1);
      chk("cont_lreq_release", 64'(lock_req_o), 64'd1);
      chk("cont_cnt", 64'(stall_cnt_o), CNT_EN ? 64'd5 : 64'd0);

      // Backpressure
      for (int i = 0; i < 4; i++) begin
         drive(1, 8'h56, 8'h02, 32'h2222, 0, 0);
         chk("bp_ready", 64'(desc_ready_o), 64'd0);
         chk("bp_valid", 64'(desc_valid_o), 64'd1);
         chk("bp_idx", 64'(desc_index_o), 64'h34);
         chk("bp_lreq", 64'(lock_req_o), 64'd0);
      end

      // Back-to-back
      drive(1, 8'h56, 8'h02, 32'h2222, 0, 1);
      chk("b2b_ready", 64'(desc_ready_o), 64'd1);
      drive(1, 8'h78, 8'h08, 32'h3333, 0, 1);
      chk("b2b_lreq1", 64'(lock_req_o), 64'd1);
      chk("b2b_idx1", 64'(lock_index_o), 64'h56);
      drive(1, 8'h78, 8'h08, 32'h3333, 0, 1);
      chk("b2b_valid", 64'(desc_valid_o), 64'd1);
      drive(0, 8'h00, 8'h00, 32'h0, 0, 1);
      chk("b2b_lreq2", 64'(lock_req_o), 64'd1);
      chk("b2b_idx2", 64'(lock_index_o), 64'h78);
      drive(0, 8'h00, 8'h00, 32'h0, 0, 1);

      // Reset mid-WAIT
      drive(1, 8'h9A, 8'h10, 32'h4444, 1, 1);
      drive(0, 8'h00, 8'h00, 32'h0, 1, 1);
      drive(0, 8'h00, 8'h00, 32'h0, 1, 1, 0);
      chk("rw_lreq", 64'(lock_req_o), 64'd0);
      chk("rw_valid", 64'(desc_valid_o), 64'd0);
      chk("rw_ready", 64'(desc_ready_o), 64'd1);
      chk("rw_cnt", 64'(stall_cnt_o), 64'd0);
      chk("rw_hold", 64'(lock_index_o), 64'd0);
      for (int i = 0; i < 3; i++) begin
         drive(0, 8'h00, 8'h00, 32'h0, 0, 1);
         chk("rw_after_lreq", 64'(lock_req_o), 64'd0);
      end

      // Saturation
      drive(1, 8'hBC, 8'h20, 32'h5555, 0, 1);
      for (int i = 0; i < 20; i++) drive(0, 8'h00, 8'h00, 32'h0, 1, 1);
      drive(0, 8'h00, 8'h00, 32'h0, 0, 1);
      chk("sat_cnt4", 64'(stall_cnt_o4), CNT_EN ? 64'd15 : 64'd0);
      chk("sat_cnt16", 64'(stall_cnt_o), CNT_EN ? 64'd20 : 64'd0);
      drive(0, 8'h00, 8'h00, 32'h0, 0, 1);

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         drive(bit'($urandom_range(0, 1)), IW'($urandom), SA'($urandom), PW'($urandom),
               ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 7),
               ($urandom_range(0, 149) != 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
